// File: rtl/nibble_word_packer.sv
// nibble_word_packer: packs changed nibbles MSB-first into words and buffers them in a show-ahead FIFO
module nibble_word_packer #(
  parameter int NIBBLES = 4,
  parameter int DEPTH = 4
) (
  input  logic                       Bclk,
  input  logic                       reset,
  input  logic [3:0]                 Din,
  output logic [4*NIBBLES-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  localparam int W = 4 * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  logic [3:0]    r_last;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_pack;
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          w_new, w_done, w_pop, w_full, w_wr;
  logic [W-1:0]  w_word;
  assign w_new  = Din != r_last;
  assign w_done = w_new && r_cnt == CW'(NIBBLES - 1);
  // pack register is cleared after each word, so the last nibble simply ORs into the low bits
  assign w_word = r_pack | W'(Din);
  assign w_pop  = out_valid && out_ready;
  assign w_full = r_level == LW'(DEPTH);
  assign w_wr   = w_done && (!w_full || w_pop);
  always_ff @(posedge Bclk) begin
    if (reset) begin
      r_last  <= '0;
      r_cnt   <= '0;
      r_pack  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_last <= Din;
      if (w_new) begin
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
        if (w_done) r_pack <= '0;
        else r_pack[W-1-4*r_cnt -: 4] <= Din;
      end
      if (w_wr) begin
        r_mem[r_wp] <= w_word;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level <= r_level + LW'(w_wr) - LW'(w_pop);
      if (w_done && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end
  assign out_data  = r_mem[r_rp];
  assign out_valid = r_level != '0;
  assign level     = r_level;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_nibble_word_packer.sv
// tb_nibble_word_packer: directed and random checks of nibble_word_packer against a queue-based model
module tb_nibble_word_packer;
  localparam int N = 4;
  localparam int D = 4;
  localparam int W = 4 * N;
  logic         Bclk = 1'b0;
  logic         reset = 1'b1;
  logic         out_ready = 1'b0;
  logic [3:0]   Din = 4'h0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic [$clog2(D):0] level;
  logic         overflow;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [3:0]   m_last;
  logic [3:0]   m_nibs[$];
  logic [W-1:0] m_fifo[$];
  bit           m_ovf;
  logic [W-1:0] got_q[$];

  nibble_word_packer #(.NIBBLES(N), .DEPTH(D)) dut (
    .Bclk(Bclk), .reset(reset), .Din(Din), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow)
  );

  always #5 Bclk = ~Bclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] word;
    bit push, pop;
    int sz;
    if (reset) begin
      m_nibs.delete();
      m_fifo.delete();
      m_ovf = 0;
      m_last = 4'h0;
    end else begin
      push = 0;
      sz = m_fifo.size();
      pop = sz > 0 && out_ready;
      if (Din != m_last) begin
        m_nibs.push_back(Din);
        if (m_nibs.size() == N) begin
          word = '0;
          foreach (m_nibs[i]) word = (word << 4) | W'(m_nibs[i]);
          m_nibs.delete();
          push = 1;
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
        if (sz < D || pop) m_fifo.push_back(word);
        else m_ovf = 1;
      end
      m_last = Din;
    end
  endtask

  initial forever begin
    @(posedge Bclk);
    model_step();
    started = 1;
  end

  initial forever begin
    @(negedge Bclk);
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
      chk("level", 32'(level), 32'(m_fifo.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_fifo.size() != 0) chk("out_data", 32'(out_data), 32'(m_fifo[0]));
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic step(input logic [3:0] d, input logic r, input logic rs);
    Din = d;
    out_ready = r;
    reset = rs;
    @(posedge Bclk);
    #1;
  endtask

  task automatic feed(input logic [W-1:0] w, input logic r);
    for (int i = 0; i < N; i++) step(w[W-1-4*i -: 4], r, 1'b0);
  endtask

  task automatic do_reset();
    step(4'($urandom_range(0, 15)), 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] words [5];
    words = '{16'h1212, 16'h3434, 16'h5656, 16'h7878, 16'h9A9A};
    // reset held for three edges with arbitrary Din
    for (int i = 0; i < 3; i++) step(4'($urandom_range(0, 15)), 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(out_data), 0);
    // basic pack, each value held two cycles
    got_q.delete();
    step(4'h1, 1'b1, 1'b0); step(4'h1, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b0); step(4'h2, 1'b1, 1'b0);
    step(4'h3, 1'b1, 1'b0); step(4'h3, 1'b1, 1'b0);
    chk("basic_not_early", 32'(out_valid), 0);
    step(4'h4, 1'b1, 1'b0);
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_data", 32'(out_data), 32'h1234);
    chk("basic_model", 32'(m_fifo[0]), 32'h1234);
    for (int i = 0; i < 3; i++) step(4'h4, 1'b1, 1'b0);
    chk("basic_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("basic_word", 32'(got_q[0]), 32'h1234);
    chk("basic_drop_valid", 32'(out_valid), 0);
    // held values ignored, output stable while stalled
    do_reset();
    step(4'h5, 1'b0, 1'b0); step(4'h5, 1'b0, 1'b0); step(4'h5, 1'b0, 1'b0);
    step(4'hA, 1'b0, 1'b0); step(4'h5, 1'b0, 1'b0); step(4'hA, 1'b0, 1'b0);
    chk("held_level", 32'(level), 1);
    chk("held_data", 32'(out_data), 32'h5A5A);
    step(4'hA, 1'b0, 1'b0); step(4'hA, 1'b0, 1'b0);
    chk("held_stable_valid", 32'(out_valid), 1);
    chk("held_stable_data", 32'(out_data), 32'h5A5A);
    // overflow: fifth word dropped
    do_reset();
    for (int i = 0; i < 4; i++) feed(words[i], 1'b0);
    chk("ovf_level4", 32'(level), 4);
    chk("ovf_not_yet", 32'(overflow), 0);
    feed(words[4], 1'b0);
    chk("ovf_level_full", 32'(level), 4);
    chk("ovf_set", 32'(overflow), 1);
    got_q.delete();
    for (int i = 0; i < 6; i++) step(4'hA, 1'b1, 1'b0);
    chk("ovf_drain_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("ovf_drain_word", 32'(got_q[i]), 32'(words[i]));
    chk("ovf_empty", 32'(out_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) feed(words[i], 1'b0);
    got_q.delete();
    for (int i = 0; i < N - 1; i++) step(words[4][W-1-4*i -: 4], 1'b0, 1'b0);
    step(words[4][3:0], 1'b1, 1'b0);
    chk("simul_level", 32'(level), 4);
    chk("simul_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) step(4'hA, 1'b1, 1'b0);
    chk("simul_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      chk("simul_first", 32'(got_q[0]), 32'h1212);
      chk("simul_fifth", 32'(got_q[4]), 32'h9A9A);
    end
    // reset mid-pack discards partial word
    do_reset();
    got_q.delete();
    step(4'h1, 1'b1, 1'b0); step(4'h2, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b1);
    step(4'h3, 1'b1, 1'b0); step(4'h4, 1'b1, 1'b0); step(4'h5, 1'b1, 1'b0); step(4'h6, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h6, 1'b1, 1'b0);
    chk("midrst_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("midrst_word", 32'(got_q[0]), 32'h3456);
    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] d;
      d = ($urandom_range(0, 2) == 0) ? Din : 4'($urandom_range(0, 15));
      step(d, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 299) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_word_packer.md
Name: nibble_word_packer

Overview:
- Consumer stage directly downstream of the Aclk-to-Bclk nibble transfer block; runs entirely in the Bclk domain.
- Watches the 4-bit transferred bus and treats each change of value as a new nibble.
- Packs NIBBLES consecutive new nibbles MSB-first into one word and buffers completed words in a small show-ahead FIFO.
- Hands words out over a valid/ready interface and flags dropped words.

Parameters:
- NIBBLES, 4, nibbles per output word; output word width W = 4*NIBBLES.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2.

Ports:
- Bclk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- Din  input  4  nibble bus from the upstream transfer stage; already Bclk-registered, so no synchronizer is needed here.
- out_data  output  W  head-of-FIFO word; meaningful only while out_valid=1.
- out_valid  output  1  FIFO is non-empty.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1 in the same cycle.
- level  output  $clog2(DEPTH)+1  number of words currently held, 0..DEPTH.
- overflow  output  1  sticky flag: at least one completed word was dropped.

Behaviour:
- Reset (reset=1 at an edge):
  - last_din=0, nib_cnt=0, pack register=0.
  - FIFO pointers=0, level=0, out_valid=0, out_data=0, overflow=0.
  - A partially packed word is discarded.
  - Reset has priority over every other event in the same cycle.
- New-nibble detection:
  - new = (Din != last_din).
  - last_din <= Din on every non-reset edge.
  - A held value is never counted twice.
  - A value equal to the reset value 0 is not counted until Din first changes away from it.
- Packing:
  - On an edge with new=1, nibble k (k = nib_cnt, 0-based) is stored at bits [W-1-4k : W-4-4k]. The first nibble lands in the MSBs.
  - nib_cnt increments and wraps from NIBBLES-1 to 0.
  - When nib_cnt==NIBBLES-1 and new=1, the full word is pushed into the FIFO on that same edge, assembled from the pack register plus the current Din.
- Latency: if the FIFO is empty, out_valid rises in the cycle after the edge that completed the word, and out_data equals that word.
- FIFO:
  - Show-ahead: out_data always presents the oldest word.
  - pop = out_valid & out_ready.
  - Push only: level+1. Pop only: level-1. Push and pop together: level unchanged, both take effect.
  - Full (level==DEPTH) with a push and no pop: the word is dropped, FIFO contents are unchanged, and overflow is set to 1 until reset.
  - Full with push and pop in the same cycle: the push is accepted and overflow is not set.
  - Empty with pop: impossible, because out_valid=0.
  - Read and write pointers wrap modulo DEPTH.
- Handshake rules:
  - out_data must stay stable while out_valid=1 and out_ready=0.
  - out_valid must not drop without a pop.
  - out_ready has no effect when out_valid=0.
- Widths:
  - nib_cnt is $clog2(NIBBLES) bits (minimum 1).
  - Pointers are $clog2(DEPTH) bits.
  - level is one bit wider than the pointers so it can represent DEPTH.

Test Plan:
- Reset: hold reset for 3 edges with arbitrary Din, then deassert with Din=0 → out_valid=0, level=0, overflow=0, out_data=0.
- Basic pack: out_ready=1; Din 0→1→2→3→4, each value held 2 cycles → exactly one word 0x1234; out_valid high for 1 cycle, starting the cycle after Din=4 is first seen.
- Held value ignored: Din 0→5→5→5→A→5→A, each value one cycle, with out_ready=0 → word 0x5A5A; level=1; out_valid stays 1 and out_data stays stable while out_ready=0.
- Overflow: out_ready=0; supply 5 words (0x1111-style alternating patterns, e.g. 0x1212, 0x3434, 0x5656, 0x7878, 0x9A9A) → level=4 after the 4th word; 5th word dropped and overflow=1; draining with out_ready=1 yields the first 4 words in order, then out_valid=0, and overflow stays 1.
- Full with simultaneous push and pop: FIFO full, out_ready=1 on the cycle a 5th word completes → level stays 4, overflow stays 0, and that word is delivered 4 pops later.
- Reset mid-pack: after nibbles 1,2 are accepted, pulse reset for 1 cycle, then supply 3,4,5,6 → first output word is 0x3456; no word containing 1 or 2 is ever produced.
